dmem_store_buffer: RTL and testbench
====================================

// Module: dmem_store_buffer
// PURPOSE
//  Write-side companion of the data-memory load path: accepts CPU store requests, queues them
//  in an in-order FIFO and drains them to the data RAM over a we/ack handshake. A store to the
//  MMIO output address updates an LED register directly and is never queued. Sits between the
//  datapath store port and the RAM write port.
// PARAMETERS
//  DEPTH      4       FIFO entries; power of 2, >= 2
//  AW         32      address width
//  DW         32      data width
//  MMIO_ADDR  32'd256 store address mapped to the LED output register
//  LED_W      8       LED register width (takes wd[LED_W-1:0])
// PORTS
//  clk        in   1   single clock; all state on posedge
//  rst_n      in   1   asynchronous, active-low reset
//  we         in   1   CPU store request, sampled when stall=0
//  a          in   AW  store byte address
//  wd         in   DW  store data
//  flush      in   1   drain request; 1-cycle pulse
//  ld_a       in   AW  current load address (forwarding lookup)
//  stall      out  1   CPU must hold store/pipeline
//  flush_done out  1   1-cycle pulse: flush finished, FIFO empty
//  mem_we     out  1   RAM write valid
//  mem_a      out  AW  RAM write address, word aligned
//  mem_wd     out  DW  RAM write data
//  mem_ack    in   1   RAM accepted the write this cycle
//  leds       out  LED_W  MMIO output register
//  misalign   out  1   sticky: store with a[1:0]!=0 was dropped
//  fwd_hit    out  1   ld_a matches a queued store (STORE_FWD_EN)
//  fwd_data   out  DW  data of youngest matching entry (STORE_FWD_EN)
// BEHAVIOUR
//  - Reset (async, immediate): FIFO emptied, state=RUN, leds=0, misalign=0; mem_we=0,
//    stall=0, flush_done=0, fwd_hit=0 while rst_n=0. Reset mid-drain drops pending stores.
//  - Accept: we=1 & stall=0. a==MMIO_ADDR -> leds<=wd[LED_W-1:0] next edge, no push.
//    a[1:0]!=0 -> store dropped, misalign<=1 (sticky until reset). Otherwise push {a,wd}.
//  - stall = full | (state!=RUN). Full is conservative: no push even if pop same cycle.
//  - Drain: mem_we = !empty; mem_a={head.a[AW-1:2],2'b00}, mem_wd=head.wd, combinational
//    from head, stable until ack. Pop on edge where mem_we & mem_ack. mem_ack with
//    mem_we=0 ignored. Max 1 pop/cycle; store-to-mem_we latency 1 cycle when empty.
//  - Simultaneous push & pop (not full): both occur, count unchanged.
//  - Pointers wrap modulo DEPTH; count width $clog2(DEPTH)+1 distinguishes full/empty.
//  - FSM: RUN -flush-> FLUSH (if FIFO empty, go straight to DONE); FLUSH -empty-> DONE;
//    DONE -> RUN unconditionally, flush_done=1 in DONE only. flush in FLUSH/DONE ignored.
//    Store presented with flush in same cycle: accepted first (stall was 0), then flushed.
//  - MMIO writes and RAM drains are unordered relative to each other.
// CONFIGURATION
//  STORE_FWD_EN defined: fwd_hit=1 when any valid entry word address == ld_a[AW-1:2];
//    fwd_data = youngest match; combinational; entry popping this cycle still counts.
//  STORE_FWD_EN undefined: no compare logic; fwd_hit=0, fwd_data=0 constantly.
// STRUCTURE
//  Package dmem_pkg: MMIO_OUT_ADDR constant, store_entry_t struct {addr, data},
//    sb_state_e enum {SB_RUN, SB_FLUSH, SB_DONE}.
//  Sub-module store_fifo: DEPTH-entry store_entry_t FIFO, push/pop/full/empty/count, exposes
//    entry array + valid mask for forwarding. Top holds FSM, MMIO decode, misalign, fwd mux.
// TESTING
//  1. Store a=0x10 wd=0xAA, mem_ack=1 -> next cycle mem_we=1 mem_a=0x10 mem_wd=0xAA; popped.
//  2. mem_ack=0, 4 stores a=0,4,8,C -> stall=1 after 4th; 5th held; ack x4 -> in-order drain.
//  3. Store a=256 wd=0x1F5 -> leds=0xF5 next cycle, mem_we stays 0.
//  4. Store a=0x6 -> dropped, misalign=1, FIFO unchanged; persists until rst_n=0.
//  5. 2 queued, flush, ack every other cycle -> stall=1 until empty, one flush_done pulse.
//  6. STORE_FWD_EN: queue a=0x20 wd=1 then wd=2, ld_a=0x22 -> fwd_hit=1 fwd_data=2;
//     rst_n=0 mid-drain -> mem_we=0, fwd_hit=0 immediately.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory store path.
// Holds the MMIO LED address, the queued store entry and the flush state encoding.
package dmem_pkg;
  localparam int SB_AW = 32;
  localparam int SB_DW = 32;

  localparam logic [SB_AW-1:0] MMIO_OUT_ADDR = 32'd256;

  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } store_entry_t;

  typedef enum logic [1:0] {SB_RUN, SB_FLUSH, SB_DONE} sb_state_e;
endpackage

// File: rtl/store_fifo.sv
// In-order FIFO of store entries with a power-of-2 depth.
// Exposes every slot plus a valid mask so the top can do load forwarding.
module store_fifo import dmem_pkg::*; #(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
)(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  store_entry_t din,
  output store_entry_t head,
  output logic         full,
  output logic         empty,
  output logic [PW:0]  count,
  output logic [PW-1:0] rd_ptr,
  output store_entry_t ent [DEPTH],
  output logic [DEPTH-1:0] vld
);
  store_entry_t mem [DEPTH];
  logic [PW-1:0] wr_ptr;

  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];
  assign ent   = mem;

  // The extra count bit separates full from empty when the pointers coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_vld
    logic [PW-1:0] age;
    assign age    = PW'(i) - rd_ptr;
    assign vld[i] = ({1'b0, age} < count);
  end
endmodule

// File: rtl/dmem_store_buffer.sv
// CPU store buffer: MMIO LED decode, misalign trap, FIFO drain to RAM and flush FSM.
// Define STORE_FWD_EN to add store-to-load forwarding from queued entries.
module dmem_store_buffer import dmem_pkg::*; #(
  parameter int             DEPTH     = 4,
  parameter int             AW        = SB_AW,
  parameter int             DW        = SB_DW,
  parameter logic [AW-1:0]  MMIO_ADDR = AW'(MMIO_OUT_ADDR),
  parameter int             LED_W     = 8
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    a,
  input  logic [DW-1:0]    wd,
  input  logic             flush,
  input  logic [AW-1:0]    ld_a,
  output logic             stall,
  output logic             flush_done,
  output logic             mem_we,
  output logic [AW-1:0]    mem_a,
  output logic [DW-1:0]    mem_wd,
  input  logic             mem_ack,
  output logic [LED_W-1:0] leds,
  output logic             misalign,
  output logic             fwd_hit,
  output logic [DW-1:0]    fwd_data
);
  localparam int PW = $clog2(DEPTH);

  store_entry_t      head, din;
  store_entry_t      ent [DEPTH];
  logic [DEPTH-1:0]  vld;
  logic [PW-1:0]     rd_ptr;
  logic [PW:0]       count;
  logic              full, empty;
  logic              accept, is_mmio, is_mis, push, pop, empty_nxt;
  sb_state_e         state;

  assign stall    = full | (state != SB_RUN);
  assign accept   = we & ~stall;
  assign is_mmio  = (a == MMIO_ADDR);
  assign is_mis   = (a[1:0] != 2'b00);
  assign push     = accept & ~is_mmio & ~is_mis;
  assign pop      = mem_we & mem_ack;
  assign din      = '{addr: SB_AW'(a), data: SB_DW'(wd)};
  // Emptiness as it will be after this edge, so a store riding with flush is drained first.
  assign empty_nxt = ~push & (empty | ((count == (PW+1)'(1)) & pop));

  store_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk, .rst_n, .push, .pop, .din, .head, .full, .empty,
    .count, .rd_ptr, .ent, .vld
  );

  assign mem_we     = ~empty;
  assign mem_a      = AW'({head.addr[SB_AW-1:2], 2'b00});
  assign mem_wd     = DW'(head.data);
  assign flush_done = (state == SB_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SB_RUN;
      leds     <= '0;
      misalign <= 1'b0;
    end else begin
      if (accept & is_mmio)           leds     <= wd[LED_W-1:0];
      if (accept & ~is_mmio & is_mis) misalign <= 1'b1;
      case (state)
        SB_RUN:   if (flush) state <= empty_nxt ? SB_DONE : SB_FLUSH;
        SB_FLUSH: if (empty_nxt) state <= SB_DONE;
        SB_DONE:  state <= SB_RUN;
        default:  state <= SB_RUN;
      endcase
    end
  end

`ifdef STORE_FWD_EN
  logic [PW-1:0] fwd_idx;

  // Walk oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = rd_ptr + PW'(k);
      if (vld[fwd_idx] &&
          ent[fwd_idx].addr[SB_AW-1:2] == (SB_AW-2)'(ld_a[AW-1:2])) begin
        fwd_hit  = 1'b1;
        fwd_data = DW'(ent[fwd_idx].data);
      end
    end
  end
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  logic [SB_AW+SB_DW-1:0]   ent_unused;
  logic [AW+DEPTH+PW-1:0]   misc_unused;
  always_comb begin
    ent_unused = head;
    for (int k = 0; k < DEPTH; k++) ent_unused = ent_unused ^ ent[k];
  end
  assign misc_unused = {ld_a, vld, rd_ptr};
endmodule

// File: tb/tb_dmem_store_buffer.sv
// Randomized bench for dmem_store_buffer against a queue-based reference model,
// with directed scenarios pinning literal expectations.
module tb_dmem_store_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0, flush = 1'b0, mem_ack = 1'b0;
  logic [31:0] a = '0, wd = '0, ld_a = '0;
  logic        stall, flush_done, mem_we, misalign, fwd_hit;
  logic [31:0] mem_a, mem_wd, fwd_data;
  logic [7:0]  leds;

  dmem_store_buffer dut (
    .clk(clk), .rst_n(rst_n), .we(we), .a(a), .wd(wd), .flush(flush), .ld_a(ld_a),
    .stall(stall), .flush_done(flush_done), .mem_we(mem_we), .mem_a(mem_a),
    .mem_wd(mem_wd), .mem_ack(mem_ack), .leds(leds), .misalign(misalign),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  typedef struct { logic [31:0] a; logic [31:0] d; } ent_t;
  ent_t       q[$];
  int         mode;      // 0 running, 1 flushing, 2 flush just finished
  logic [7:0] m_leds;
  logic       m_mis;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    mode = 0; m_leds = '0; m_mis = 1'b0;
  endtask

  // Drive one cycle, compare all outputs against the model, then advance the model.
  task automatic step(input logic i_we, input logic [31:0] i_a, input logic [31:0] i_wd,
                      input logic i_fl, input logic i_ack, input logic [31:0] i_ld);
    logic e_stall, e_hit, pop, acc;
    logic [31:0] e_fd;
    @(negedge clk);
    we = i_we; a = i_a; wd = i_wd; flush = i_fl; mem_ack = i_ack; ld_a = i_ld;
    #1;
    e_stall = (q.size() == DEPTH) || (mode != 0);
    chk("stall", stall, e_stall);
    chk("mem_we", mem_we, q.size() != 0);
    if (q.size() != 0) begin
      chk("mem_a", mem_a, q[0].a & 32'hFFFF_FFFC);
      chk("mem_wd", mem_wd, q[0].d);
    end
    chk("flush_done", flush_done, mode == 2);
    chk("leds", leds, m_leds);
    chk("misalign", misalign, m_mis);
    e_hit = 1'b0; e_fd = '0;
`ifdef STORE_FWD_EN
    foreach (q[i]) if (q[i].a[31:2] == i_ld[31:2]) begin e_hit = 1'b1; e_fd = q[i].d; end
`endif
    chk("fwd_hit", fwd_hit, e_hit);
    chk("fwd_data", fwd_data, e_fd);
    pop = (q.size() != 0) && i_ack;
    acc = i_we && !e_stall;
    if (pop) void'(q.pop_front());
    if (acc) begin
      if (i_a == 32'd256)        m_leds = i_wd[7:0];
      else if (i_a[1:0] != 2'b0) m_mis = 1'b1;
      else                       q.push_back('{a: i_a, d: i_wd});
    end
    case (mode)
      0: if (i_fl) mode = (q.size() == 0) ? 2 : 1;
      1: if (q.size() == 0) mode = 2;
      default: mode = 0;
    endcase
  endtask

  task automatic idle(input logic i_ack);
    step(1'b0, 32'h0, 32'h0, 1'b0, i_ack, ld_a);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; we = 1'b0; flush = 1'b0; mem_ack = 1'b0;
    #1;
    chk("rst mem_we", mem_we, 1'b0);
    chk("rst stall", stall, 1'b0);
    chk("rst flush_done", flush_done, 1'b0);
    chk("rst fwd_hit", fwd_hit, 1'b0);
    chk("rst leds", leds, 8'h0);
    chk("rst misalign", misalign, 1'b0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int dones;
    logic [31:0] ra;
    model_clear();
    #2;
    chk("por mem_we", mem_we, 1'b0);
    chk("por stall", stall, 1'b0);
    chk("por leds", leds, 8'h0);
    @(negedge clk); rst_n = 1'b1;

    // Single store drains one cycle later
    step(1'b1, 32'h10, 32'hAA, 1'b0, 1'b1, 32'h0);
    chk("t1 empty before", mem_we, 1'b0);
    idle(1'b1);
    chk("t1 mem_we", mem_we, 1'b1);
    chk("t1 mem_a", mem_a, 32'h10);
    chk("t1 mem_wd", mem_wd, 32'hAA);
    idle(1'b1);
    chk("t1 popped", mem_we, 1'b0);

    // Fill, stall, in-order drain
    for (int i = 0; i < 4; i++) step(1'b1, 32'(i*4), 32'(100+i), 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h14, 32'h5, 1'b0, 1'b0, 32'h0);
    chk("t2 stall full", stall, 1'b1);
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      chk("t2 drain a", mem_a, 32'(i*4));
      chk("t2 drain d", mem_wd, 32'(100+i));
    end
    idle(1'b0);
    chk("t2 drained", mem_we, 1'b0);

    // MMIO store
    step(1'b1, 32'd256, 32'h1F5, 1'b0, 1'b1, 32'h0);
    idle(1'b1);
    chk("t3 leds", leds, 8'hF5);
    chk("t3 no mem_we", mem_we, 1'b0);

    // Misaligned store dropped
    step(1'b1, 32'h6, 32'h77, 1'b0, 1'b1, 32'h0);
    idle(1'b1);
    chk("t4 misalign", misalign, 1'b1);
    chk("t4 no mem_we", mem_we, 1'b0);

    // Flush with slow acks
    step(1'b1, 32'h40, 32'h1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h44, 32'h2, 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      idle(i[0]);
      if (i == 0) chk("t5 stall flushing", stall, 1'b1);
      dones += int'(flush_done);
    end
    chk("t5 done pulses", dones, 1);
    chk("t5 misalign sticky", misalign, 1'b1);

    // Forwarding, then reset mid-drain
    step(1'b1, 32'h20, 32'h1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h20, 32'h2, 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h22);
`ifdef STORE_FWD_EN
    chk("t6 fwd_hit", fwd_hit, 1'b1);
    chk("t6 fwd_data", fwd_data, 32'h2);
`else
    chk("t6 fwd_hit off", fwd_hit, 1'b0);
`endif
    do_reset();
    idle(1'b1);
    chk("t6 dropped", mem_we, 1'b0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      case ($urandom_range(0, 63))
        0:       ra = 32'h0000_0001 << $urandom_range(0, 1);
        1, 2, 3: ra = 32'd256;
        default: ra = 32'($urandom_range(0, 15)) << 2;
      endcase
      step(1'($urandom_range(0, 1)), ra, $urandom,
           $urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)),
           32'($urandom_range(0, 63)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
